wb_imem_dmem_arb: RTL
=====================

WB_IMEM_DMEM_ARB -- requirements
Module: wb_imem_dmem_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: cycles a granted transfer may wait for slave ack/err before the arbiter aborts it; legal range 1..255.
REQ-002 Parameter AW, default 32: address and data width (SCR1_WB_WIDTH).
REQ-003 The block SHALL have one clock, wb_clk, and one reset, wb_rst; wb_rst is synchronous and active-high.
REQ-004 wb_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 wb_rst  in  1  synchronous active-high reset.
REQ-006 wbm_imem_stb_i/adr_i/we_i/dat_i/sel_i  in  1/AW/1/AW/4  instruction-master request.
REQ-007 wbm_imem_dat_o/ack_o/err_o  out  AW/1/1  instruction-master response.
REQ-008 wbm_dmem_stb_i/adr_i/we_i/dat_i/sel_i  in  1/AW/1/AW/4  data-master request.
REQ-009 wbm_dmem_dat_o/ack_o/err_o  out  AW/1/1  data-master response.
REQ-010 wbs_stb_o/adr_o/we_o/dat_o/sel_o  out  1/AW/1/AW/4  shared memory-port request.
REQ-011 wbs_dat_i/ack_i/err_i  in  AW/1/1  shared memory-port response.
REQ-012 arb_timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-013 FSM states: IDLE, GNT_IMEM, GNT_DMEM; state, last_grant and timeout counter are registered.
REQ-014 IDLE: only imem stb -> GNT_IMEM; only dmem stb -> GNT_DMEM; both -> grant the master not equal to last_grant (round-robin); neither -> stay IDLE.
REQ-015 Entering a GNT state SHALL update last_grant to that master and clear the timeout counter.
REQ-016 wbs_stb_o = granted master's stb while in GNT state, else 0; adr/we/dat/sel SHALL mux from the granted master, and SHALL be 0 in IDLE.
REQ-017 Slave stb SHALL assert the cycle after the request is first seen in IDLE (1-cycle arbitration latency).
REQ-018 wbs_ack_i/err_i/dat_i SHALL route combinationally to the granted master only; the non-granted master's ack_o/err_o SHALL be 0 and dat_o SHALL be 0.
REQ-019 On wbs_ack_i or wbs_err_i in a GNT state -> IDLE next cycle; at least one IDLE cycle separates grants.
REQ-020 Granted master dropping stb before ack (abort) -> IDLE next cycle; slave stb deasserts in the same cycle through the gating.
REQ-021 Timeout counter (8 bit, saturating) increments each GNT cycle without ack/err; when it equals TIMEOUT_CYC-1 with no response, the arbiter SHALL assert err_o to the granted master and arb_timeout_o for that cycle, then return to IDLE.
REQ-022 ack and timeout in the same cycle: ack wins; no err_o, no arb_timeout_o.
REQ-023 wbs_ack_i or wbs_err_i in IDLE SHALL be ignored: no master response, no state change.
REQ-024 Masters SHALL hold request fields stable until ack/err; the arbiter does not register request fields.

Reset
REQ-025 wb_rst: state=IDLE, last_grant=IMEM (so DMEM wins the first tie), counter=0.
REQ-026 All outputs SHALL be 0 during reset and in the first cycle after it.
REQ-027 Reset mid-transfer SHALL drop wbs_stb_o the next cycle, with no ack/err forwarded to either master.

Structure
REQ-028 Package wb_arb_pkg SHALL hold the state enum, the master-ID enum (IMEM/DMEM) and the TIMEOUT_CYC default.
REQ-029 One sub-module, wb_arb_timeout (clear, enable, limit -> expired), SHALL hold the counter; priority selection and muxing stay inline.

Verification
REQ-030 imem read only, slave acks 2 cycles after stb -> wbs_stb_o at cycle 1, imem ack_o at cycle 3 carrying slave data 0xDEADBEEF; dmem sees nothing.
REQ-031 Both request in the same cycle after reset -> DMEM granted first, IMEM second, with one IDLE cycle between.
REQ-032 Both requesting continuously, slave ack after 1 cycle -> grants alternate D,I,D,I for 8 transfers with no starvation.
REQ-033 Slave never responds, TIMEOUT_CYC=4 -> dmem err_o and arb_timeout_o pulse together on the 4th grant cycle; next grant proceeds normally.
REQ-034 wb_rst asserted on the 2nd cycle of a granted imem write -> wbs_stb_o=0 next cycle, no ack/err to imem, and after release DMEM wins the first tie.
REQ-035 Spurious wbs_ack_i in IDLE -> both masters' ack_o stay 0 and the state is unchanged.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and defaults for the imem/dmem Wishbone arbiter
package wb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GNT_IMEM = 2'd1,
      ST_GNT_DMEM = 2'd2
   } arb_state_t;

   typedef enum logic {
      MST_IMEM = 1'b0,
      MST_DMEM = 1'b1
   } master_id_t;

   localparam int unsigned TIMEOUT_CYC_DEF = 255;
   localparam int unsigned AW_DEF          = 32;
   localparam int unsigned TCNT_W          = 8;

endpackage

// File: rtl/wb_imem_dmem_arb_if.sv
// rtl/wb_imem_dmem_arb_if.sv - bundled master/slave Wishbone signals around the arbiter
interface wb_imem_dmem_arb_if import wb_arb_pkg::*; #(parameter int AW = AW_DEF);

   logic          wbm_imem_stb_i;
   logic [AW-1:0] wbm_imem_adr_i;
   logic          wbm_imem_we_i;
   logic [AW-1:0] wbm_imem_dat_i;
   logic [3:0]    wbm_imem_sel_i;
   logic [AW-1:0] wbm_imem_dat_o;
   logic          wbm_imem_ack_o;
   logic          wbm_imem_err_o;

   logic          wbm_dmem_stb_i;
   logic [AW-1:0] wbm_dmem_adr_i;
   logic          wbm_dmem_we_i;
   logic [AW-1:0] wbm_dmem_dat_i;
   logic [3:0]    wbm_dmem_sel_i;
   logic [AW-1:0] wbm_dmem_dat_o;
   logic          wbm_dmem_ack_o;
   logic          wbm_dmem_err_o;

   logic          wbs_stb_o;
   logic [AW-1:0] wbs_adr_o;
   logic          wbs_we_o;
   logic [AW-1:0] wbs_dat_o;
   logic [3:0]    wbs_sel_o;
   logic [AW-1:0] wbs_dat_i;
   logic          wbs_ack_i;
   logic          wbs_err_i;

   logic          arb_timeout_o;

   // Arbiter-side view.
   modport slave (
      input  wbm_imem_stb_i, wbm_imem_adr_i, wbm_imem_we_i, wbm_imem_dat_i, wbm_imem_sel_i,
      output wbm_imem_dat_o, wbm_imem_ack_o, wbm_imem_err_o,
      input  wbm_dmem_stb_i, wbm_dmem_adr_i, wbm_dmem_we_i, wbm_dmem_dat_i, wbm_dmem_sel_i,
      output wbm_dmem_dat_o, wbm_dmem_ack_o, wbm_dmem_err_o,
      output wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i,
      output arb_timeout_o
   );

   // Environment view: the two CPU masters plus the shared memory.
   modport master (
      output wbm_imem_stb_i, wbm_imem_adr_i, wbm_imem_we_i, wbm_imem_dat_i, wbm_imem_sel_i,
      input  wbm_imem_dat_o, wbm_imem_ack_o, wbm_imem_err_o,
      output wbm_dmem_stb_i, wbm_dmem_adr_i, wbm_dmem_we_i, wbm_dmem_dat_i, wbm_dmem_sel_i,
      input  wbm_dmem_dat_o, wbm_dmem_ack_o, wbm_dmem_err_o,
      input  wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o,
      output wbs_dat_i, wbs_ack_i, wbs_err_i,
      input  arb_timeout_o
   );

endinterface

// File: rtl/wb_arb_timeout.sv
// rtl/wb_arb_timeout.sv - saturating wait counter that flags when a grant has waited too long
module wb_arb_timeout import wb_arb_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              enable,
   input  logic [TCNT_W-1:0] limit,
   output logic              expired
);

   logic [TCNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   // Count starts at 0 on the first grant cycle, so limit-1 marks the limit-th cycle.
   assign expired = (count == (limit - {{(TCNT_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/wb_imem_dmem_arb.sv
// rtl/wb_imem_dmem_arb.sv - round-robin arbiter sharing one Wishbone memory port between imem and dmem
module wb_imem_dmem_arb import wb_arb_pkg::*; #(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int          AW          = AW_DEF
) (
   input  logic               wb_clk,
   input  logic               wb_rst,
   wb_imem_dmem_arb_if.slave  bus
);

   localparam logic [TCNT_W-1:0] TMO_LIMIT = TCNT_W'(TIMEOUT_CYC);

   arb_state_t state, state_nxt;
   master_id_t last_grant, last_grant_nxt;

   logic gnt_imem, gnt_dmem, gnt_stb, slv_resp;
   logic tmo_expired, tmo_fire;

   assign gnt_imem = (state == ST_GNT_IMEM);
   assign gnt_dmem = (state == ST_GNT_DMEM);
   assign gnt_stb  = (gnt_imem & bus.wbm_imem_stb_i) | (gnt_dmem & bus.wbm_dmem_stb_i);
   assign slv_resp = bus.wbs_ack_i | bus.wbs_err_i;
   // A real slave response in the same cycle always beats the timeout.
   assign tmo_fire = gnt_stb & ~slv_resp & tmo_expired;

   wb_arb_timeout u_timeout (
      .clk     (wb_clk),
      .rst     (wb_rst),
      .clear   (state == ST_IDLE),
      .enable  (gnt_stb & ~slv_resp),
      .limit   (TMO_LIMIT),
      .expired (tmo_expired)
   );

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state      <= ST_IDLE;
         last_grant <= MST_IMEM;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         ST_IDLE: begin
            if (bus.wbm_imem_stb_i && bus.wbm_dmem_stb_i) begin
               if (last_grant == MST_IMEM) begin
                  state_nxt      = ST_GNT_DMEM;
                  last_grant_nxt = MST_DMEM;
               end else begin
                  state_nxt      = ST_GNT_IMEM;
                  last_grant_nxt = MST_IMEM;
               end
            end else if (bus.wbm_imem_stb_i) begin
               state_nxt      = ST_GNT_IMEM;
               last_grant_nxt = MST_IMEM;
            end else if (bus.wbm_dmem_stb_i) begin
               state_nxt      = ST_GNT_DMEM;
               last_grant_nxt = MST_DMEM;
            end
         end
         ST_GNT_IMEM, ST_GNT_DMEM: begin
            if (!gnt_stb || slv_resp || tmo_fire) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Everything is forced low while reset is held so a transfer in flight is cut immediately.
   always_comb begin
      bus.wbs_stb_o      = 1'b0;
      bus.wbs_adr_o      = {AW{1'b0}};
      bus.wbs_we_o       = 1'b0;
      bus.wbs_dat_o      = {AW{1'b0}};
      bus.wbs_sel_o      = 4'h0;
      bus.wbm_imem_dat_o = {AW{1'b0}};
      bus.wbm_imem_ack_o = 1'b0;
      bus.wbm_imem_err_o = 1'b0;
      bus.wbm_dmem_dat_o = {AW{1'b0}};
      bus.wbm_dmem_ack_o = 1'b0;
      bus.wbm_dmem_err_o = 1'b0;
      bus.arb_timeout_o  = 1'b0;
      if (!wb_rst) begin
         bus.arb_timeout_o = tmo_fire;
         if (gnt_imem) begin
            bus.wbs_stb_o      = bus.wbm_imem_stb_i;
            bus.wbs_adr_o      = bus.wbm_imem_adr_i;
            bus.wbs_we_o       = bus.wbm_imem_we_i;
            bus.wbs_dat_o      = bus.wbm_imem_dat_i;
            bus.wbs_sel_o      = bus.wbm_imem_sel_i;
            bus.wbm_imem_dat_o = bus.wbs_dat_i;
            bus.wbm_imem_ack_o = bus.wbs_ack_i;
            bus.wbm_imem_err_o = bus.wbs_err_i | tmo_fire;
         end else if (gnt_dmem) begin
            bus.wbs_stb_o      = bus.wbm_dmem_stb_i;
            bus.wbs_adr_o      = bus.wbm_dmem_adr_i;
            bus.wbs_we_o       = bus.wbm_dmem_we_i;
            bus.wbs_dat_o      = bus.wbm_dmem_dat_i;
            bus.wbs_sel_o      = bus.wbm_dmem_sel_i;
            bus.wbm_dmem_dat_o = bus.wbs_dat_i;
            bus.wbm_dmem_ack_o = bus.wbs_ack_i;
            bus.wbm_dmem_err_o = bus.wbs_err_i | tmo_fire;
         end
      end
   end

endmodule
